uart_rx_core: RTL and testbench

//  Serial-to-parallel UART receiver; counterpart of the team's 8N1 transmitter on the same link.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_core.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encoding, frame position codes, data width.
// Used by the receiver (uart_rx_core) and the matching 8N1 transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BCNT_W    = 4;

    // Frame position code while no frame is in progress
    localparam logic [BCNT_W-1:0] BCNT_IDLE = 4'hf;

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    // Even-parity bit for a data byte
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1, tick_c high while at DIV-1.
// clr restarts the count so the tick phase aligns to a detected start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Divider counter, explicit reload at terminal count or on clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/8 data (LSB first)/stop framing with a
// valid/ack handshake and sticky overrun flag.
// Optional: define UART_RX_PARITY_EN for an even-parity bit and perr output.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 54,
    parameter int unsigned OVS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxsd,
    input  logic                 rxack,
    output logic [DATA_BITS-1:0] rxpd,
    output logic                 rxvalid,
    output logic                 ferr,
`ifdef UART_RX_PARITY_EN
    output logic                 perr,
`endif
    output logic                 ovr,
    output logic [BCNT_W-1:0]    bcnt
);

    localparam int unsigned SC_W = $clog2(OVS);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVS / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVS - 1);
    localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam logic [BCNT_W-1:0] LAST_POS = BCNT_W'(DATA_BITS + 1);
`else
    localparam logic [BCNT_W-1:0] LAST_POS = BCNT_W'(DATA_BITS);
`endif

    uart_state_e          state, state_nxt;
    logic [SC_W-1:0]      sc, sc_nxt;
    logic [BCNT_W-1:0]    bcnt_nxt;
    logic [DATA_BITS-1:0] sr, sr_nxt;
    logic [DATA_BITS-1:0] rxpd_nxt;
    logic                 rxvalid_nxt, ferr_nxt, ovr_nxt;
    logic                 rx_meta, rxs, rxs_q;
    logic                 tick_c, start_c, done_c, ack_c;
`ifdef UART_RX_PARITY_EN
    logic                 par, par_nxt, perr_nxt;
`endif

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_c),
        .tick_c (tick_c)
    );

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rxsd;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    // Frame FSM next-state: start check at half bit, then one sample per bit
    always_comb begin
        state_nxt = state;
        sc_nxt    = sc;
        bcnt_nxt  = bcnt;
        sr_nxt    = sr;
        start_c   = 1'b0;
        done_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            ST_ARM: begin
                if (rxs) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rxs_q && !rxs) begin
                    state_nxt = ST_START;
                    sc_nxt    = '0;
                    bcnt_nxt  = '0;
                    start_c   = 1'b1;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (sc == SC_MID) begin
                        sc_nxt = '0;
                        if (rxs) begin
                            state_nxt = ST_IDLE;
                            bcnt_nxt  = BCNT_IDLE;
                        end else begin
                            state_nxt = ST_DATA;
                            bcnt_nxt  = BCNT_W'(1);
                        end
                    end else begin
                        sc_nxt = sc + SC_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (sc == SC_LAST) begin
                        sc_nxt   = '0;
                        bcnt_nxt = bcnt + BCNT_W'(1);
                        if (bcnt <= DATA_LAST) begin
                            sr_nxt = {rxs, sr[DATA_BITS-1:1]};
                        end
`ifdef UART_RX_PARITY_EN
                        else begin
                            par_nxt = rxs;
                        end
`endif
                        if (bcnt == LAST_POS) begin
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        sc_nxt = sc + SC_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (sc == SC_LAST) begin
                        sc_nxt    = '0;
                        bcnt_nxt  = BCNT_IDLE;
                        state_nxt = ST_ARM;
                        done_c    = 1'b1;
                    end else begin
                        sc_nxt = sc + SC_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_ARM;
                bcnt_nxt  = BCNT_IDLE;
                sc_nxt    = '0;
            end
        endcase
    end

    // Output handshake: load on completion (overrun if still unacked), clear on ack
    always_comb begin
        ack_c       = rxack && rxvalid;
        rxpd_nxt    = rxpd;
        rxvalid_nxt = rxvalid;
        ferr_nxt    = ferr;
        ovr_nxt     = ovr;
`ifdef UART_RX_PARITY_EN
        perr_nxt    = perr;
`endif
        if (done_c) begin
            rxpd_nxt    = sr;
            rxvalid_nxt = 1'b1;
            ferr_nxt    = !rxs;
            ovr_nxt     = (rxvalid && !rxack) || (ovr && !ack_c);
`ifdef UART_RX_PARITY_EN
            perr_nxt    = even_parity(sr) ^ par;
`endif
        end else if (ack_c) begin
            rxvalid_nxt = 1'b0;
            ferr_nxt    = 1'b0;
            ovr_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_nxt    = 1'b0;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_ARM;
            sc      <= '0;
            bcnt    <= BCNT_IDLE;
            sr      <= '0;
            rxpd    <= '0;
            rxvalid <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par     <= 1'b0;
            perr    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            sc      <= sc_nxt;
            bcnt    <= bcnt_nxt;
            sr      <= sr_nxt;
            rxpd    <= rxpd_nxt;
            rxvalid <= rxvalid_nxt;
            ferr    <= ferr_nxt;
            ovr     <= ovr_nxt;
`ifdef UART_RX_PARITY_EN
            par     <= par_nxt;
            perr    <= perr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core (DIV=4, OVS=16).
// Honours UART_RX_PARITY_EN for the parity frames and perr checks.
module tb_uart_rx_core;

    localparam int unsigned DIV = 4;
    localparam int unsigned OVS = 16;
    localparam int BIT_CLK = DIV * OVS;
`ifdef UART_RX_PARITY_EN
    localparam int LAST_POS = 10;
`else
    localparam int LAST_POS = 9;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxsd = 1'b1;
    logic       rxack = 1'b0;
    logic [7:0] rxpd;
    logic       rxvalid, ferr, ovr;
    logic [3:0] bcnt;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    exp_t       sb[$];
    logic [3:0] seq[$];
    logic [3:0] last_b = 4'h0;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;

    uart_rx_core #(.DIV(DIV), .OVS(OVS)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxsd    (rxsd),
        .rxack   (rxack),
        .rxpd    (rxpd),
        .rxvalid (rxvalid),
        .ferr    (ferr),
`ifdef UART_RX_PARITY_EN
        .perr    (perr),
`endif
        .ovr     (ovr),
        .bcnt    (bcnt)
    );

    always #5 clk = ~clk;

    // Record every change of the frame position while enabled
    always @(negedge clk) begin
        if (mon_en) begin
            if (bcnt !== last_b) seq.push_back(bcnt);
            last_b <= bcnt;
        end else begin
            last_b <= 4'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxsd = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Drive one frame and push its expected result; flip inverts the parity bit
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic flip);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.perr = flip;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ flip);
`endif
        send_bit(stop);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (rxvalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rxvalid), 32'd1);
    endtask

    // Pop the oldest expected frame and compare against the held outputs
    task automatic check_frame(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rxpd"}, 32'(rxpd), 32'(e.data));
            check({tag, "_ferr"}, 32'(ferr), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
            check({tag, "_perr"}, 32'(perr), 32'(e.perr));
`endif
        end
    endtask

    task automatic do_ack();
        rxack = 1'b1;
        @(negedge clk);
        rxack = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq[$];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rxpd", 32'(rxpd), 32'h0);
        check("rst_rxvalid", 32'(rxvalid), 32'h0);
        check("rst_ferr", 32'(ferr), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        check("rst_bcnt", 32'(bcnt), 32'hf);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Good frame 0xA5 with bcnt trace
        mon_en = 1'b1;
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_valid("a5_valid");
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check_frame("a5");
        check("a5_ovr", 32'(ovr), 32'h0);
        exp_seq.push_back(4'hf);
        for (int i = 0; i <= LAST_POS; i++) exp_seq.push_back(4'(i));
        exp_seq.push_back(4'hf);
        check("a5_bcnt_len", 32'(seq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
            check($sformatf("a5_bcnt_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        do_ack();
        check("a5_ack_rxvalid", 32'(rxvalid), 32'h0);

        // Framing error 0x3C, then hold the line low
        send_byte(8'h3C, 1'b0, 1'b0);
        wait_valid("3c_valid");
        check_frame("3c");
        do_ack();
        check("3c_ack_ferr", 32'(ferr), 32'h0);
        repeat (300) @(negedge clk);
        check("low_bcnt", 32'(bcnt), 32'hf);
        check("low_rxvalid", 32'(rxvalid), 32'h0);
        rxsd = 1'b1;
        repeat (40) @(negedge clk);
        check("high_bcnt", 32'(bcnt), 32'hf);

        // Short low glitch: 4 oversample ticks
        rxsd = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rxsd = 1'b1;
        check("glitch_start_bcnt", 32'(bcnt), 32'h0);
        repeat (60) @(negedge clk);
        check("glitch_bcnt", 32'(bcnt), 32'hf);
        check("glitch_rxvalid", 32'(rxvalid), 32'h0);
        repeat (20) @(negedge clk);

        // Overrun: two frames back to back without ack
        send_byte(8'h11, 1'b1, 1'b0);
        check("ovr_first_valid", 32'(rxvalid), 32'h1);
        check("ovr_first_ovr", 32'(ovr), 32'h0);
        send_byte(8'h22, 1'b1, 1'b0);
        wait_valid("ovr_valid");
        void'(sb.pop_front());
        check_frame("ovr");
        check("ovr_set", 32'(ovr), 32'h1);
        do_ack();
        check("ovr_ack_rxvalid", 32'(rxvalid), 32'h0);
        check("ovr_ack_ovr", 32'(ovr), 32'h0);
        repeat (20) @(negedge clk);

        // Reset in the middle of 0xFF at bcnt=5
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("mid_bcnt5", 32'(bcnt), 32'h5);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rxpd", 32'(rxpd), 32'h0);
        check("mid_rst_rxvalid", 32'(rxvalid), 32'h0);
        check("mid_rst_ferr", 32'(ferr), 32'h0);
        check("mid_rst_ovr", 32'(ovr), 32'h0);
        check("mid_rst_bcnt", 32'(bcnt), 32'hf);
        @(negedge clk);
        rst = 1'b1;
        repeat (6 * BIT_CLK) @(negedge clk);
        check("mid_after_rxvalid", 32'(rxvalid), 32'h0);
        send_byte(8'h5A, 1'b1, 1'b0);
        wait_valid("5a_valid");
        check_frame("5a");
        check("5a_ovr", 32'(ovr), 32'h0);
        do_ack();
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Parity: correct then inverted parity bit on 0x07
        send_byte(8'h07, 1'b1, 1'b0);
        wait_valid("par_ok_valid");
        check_frame("par_ok");
        do_ack();
        check("par_ack_perr", 32'(perr), 32'h0);
        repeat (20) @(negedge clk);
        send_byte(8'h07, 1'b1, 1'b1);
        wait_valid("par_bad_valid");
        check_frame("par_bad");
        do_ack();
        check("par_bad_ack_perr", 32'(perr), 32'h0);
        repeat (20) @(negedge clk);
`endif

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
